// File: rtl/pipeline_selftest_pkg.sv
// Shared types and defaults for the pipeline self-test controller.
// Latency/backpressure: n/a (package only).
package pipeline_selftest_pkg;

  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;
  localparam int WDOG_W  = 16;
  localparam int DLY_W   = 8;

  localparam logic [63:0]       DEF_START_PC   = 64'h0;
  localparam int                DEF_RST_CYCLES = 5;
  localparam int                DEF_WB_DELAY   = 4;
  localparam int                DEF_NUM_CHECKS = 2;
  localparam logic [WDOG_W-1:0] DEF_WDOG_MAX   = 16'h7FFF;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE,
    ST_TOUT
  } state_e;

  typedef struct packed {
    logic             all_passed;
    logic             fail_vld;
    logic [IDX_W-1:0] first_fail_idx;
    logic [CNT_W-1:0] pass_cnt;
  } result_t;

  function automatic logic wdog_active(input state_e s);
    return (s == ST_WAIT) || (s == ST_DRAIN) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/pipeline_selftest_watchdog.sv
// Hang watchdog: 16-bit cycle counter with enable and synchronous clear.
// Latency: expire is combinational on the cycle that is the WDOG_MAX-th counted one.
// Backpressure: none.
module selftest_watchdog
  import pipeline_selftest_pkg::*;
#(
  parameter logic [WDOG_W-1:0] WDOG_MAX = DEF_WDOG_MAX
) (
  input  logic Clk,
  input  logic Rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [WDOG_W-1:0] cnt_q, cnt_d, cnt_inc;

  // The current enabled cycle is counted, so the running count is cnt_q + 1.
  assign cnt_inc = cnt_q + 16'd1;
  assign expire  = en && (cnt_inc == WDOG_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_selftest_ctrl.sv
// On-chip driver/checker for the pipeline: holds reset, waits for checkpoint PCs, compares dMemOut.
// Latency: WB_DELAY drain cycles + 1 compare cycle per checkpoint; outputs decoded from registers.
// Backpressure: none; the pipeline free-runs and the watchdog bounds the sequence.
module pipeline_selftest_ctrl
  import pipeline_selftest_pkg::*;
#(
  parameter logic [63:0]       START_PC   = DEF_START_PC,
  parameter int                RST_CYCLES = DEF_RST_CYCLES,
  parameter int                WB_DELAY   = DEF_WB_DELAY,
  parameter int                NUM_CHECKS = DEF_NUM_CHECKS,
  parameter logic [WDOG_W-1:0] WDOG_MAX   = DEF_WDOG_MAX
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [63:0]       FetchedPC,
  input  logic [63:0]       dMemOut,
  output logic [IDX_W-1:0]  CkptIdx,
  input  logic [63:0]       CkptPC,
  input  logic [63:0]       CkptExp,
  output logic              PipeRst,
  output logic [63:0]       startPC,
  output logic              Done,
  output logic              AllPassed,
  output logic [CNT_W-1:0]  PassCount,
  output logic              FailValid,
  output logic [IDX_W-1:0]  FirstFailIdx,
  output logic              Timeout
);

  localparam logic [DLY_W-1:0] HOLD_LAST = DLY_W'(RST_CYCLES - 1);
  localparam logic [DLY_W-1:0] DRAIN_LD  = DLY_W'(WB_DELAY);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0] NUM_CNT   = CNT_W'(NUM_CHECKS);

  state_e           state_q, state_d;
  logic [DLY_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DLY_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  result_t          res_q, res_d;
  logic             wdog_expire;
  logic             ckpt_hit;
  logic             data_match;

  selftest_watchdog #(
    .WDOG_MAX (WDOG_MAX)
  ) u_wdog (
    .Clk    (Clk),
    .Rst    (Rst),
    .en     (wdog_active(state_q)),
    .clr    (state_q == ST_HOLD),
    .expire (wdog_expire)
  );

  assign ckpt_hit   = (FetchedPC >= CkptPC);
  assign data_match = (dMemOut == CkptExp);

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    drain_cnt_d = drain_cnt_q;
    idx_d       = idx_q;
    res_d       = res_q;

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_WAIT;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        if (ckpt_hit) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LD;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == 8'd1) begin
          state_d = ST_CHECK;
        end else begin
          drain_cnt_d = drain_cnt_q - 8'd1;
        end
      end
      ST_CHECK: begin
        if (data_match) begin
          if (res_q.pass_cnt < NUM_CNT) begin
            res_d.pass_cnt = res_q.pass_cnt + 4'd1;
          end
        end else if (!res_q.fail_vld) begin
          res_d.fail_vld       = 1'b1;
          res_d.first_fail_idx = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d          = ST_DONE;
          // Latched on entry so AllPassed is a plain register in DONE.
          res_d.all_passed = (res_d.pass_cnt == NUM_CNT) && !res_d.fail_vld;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_WAIT;
        end
      end
      default: ;
    endcase

    // Expiry wins over everything, discarding a compare made in the same cycle.
    if (wdog_expire) begin
      state_d     = ST_TOUT;
      drain_cnt_d = drain_cnt_q;
      idx_d       = idx_q;
      res_d       = res_q;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      drain_cnt_q <= '0;
      idx_q       <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
    end
  end

  assign CkptIdx      = idx_q;
  assign PipeRst      = (state_q == ST_HOLD);
  assign startPC      = START_PC;
  assign Done         = (state_q == ST_DONE) || (state_q == ST_TOUT);
  assign Timeout      = (state_q == ST_TOUT);
  assign AllPassed    = (state_q == ST_DONE) && res_q.all_passed;
  assign PassCount    = res_q.pass_cnt;
  assign FailValid    = res_q.fail_vld;
  assign FirstFailIdx = res_q.first_fail_idx;

endmodule

// File: tb/tb_pipeline_selftest_ctrl.sv
// Directed bench: dut runs default parameters; dut_w uses a short watchdog that expires on a CHECK cycle.
module tb_pipeline_selftest_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [63:0] fpc = 64'h0;
  logic        bad0 = 1'b0;
  logic        stuck = 1'b0;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  logic [2:0]  CkptIdx, FirstFailIdx;
  logic [63:0] CkptPC, CkptExp, dMemOut, startPC;
  logic [3:0]  PassCount;
  logic        PipeRst, Done, AllPassed, FailValid, Timeout;

  logic [2:0]  CkptIdx_w, FirstFailIdx_w;
  logic [63:0] CkptPC_w, CkptExp_w, dMemOut_w, startPC_w;
  logic [3:0]  PassCount_w;
  logic        PipeRst_w, Done_w, AllPassed_w, FailValid_w, Timeout_w;

  always #5 Clk = ~Clk;

  // Checkpoint ROM models
  assign CkptPC    = (CkptIdx == 3'd0) ? 64'h58 : 64'h100;
  assign CkptExp   = (CkptIdx == 3'd0) ? 64'hF  : 64'h123456789abcdef0;
  assign dMemOut   = (bad0 && CkptIdx == 3'd0) ? 64'hE : CkptExp;
  assign CkptPC_w  = (CkptIdx_w == 3'd0) ? 64'h58 : 64'h100;
  assign CkptExp_w = (CkptIdx_w == 3'd0) ? 64'hF  : 64'h123456789abcdef0;
  assign dMemOut_w = CkptExp_w;

  pipeline_selftest_ctrl dut (
    .Clk(Clk), .Rst(Rst), .FetchedPC(fpc), .dMemOut(dMemOut),
    .CkptIdx(CkptIdx), .CkptPC(CkptPC), .CkptExp(CkptExp),
    .PipeRst(PipeRst), .startPC(startPC), .Done(Done), .AllPassed(AllPassed),
    .PassCount(PassCount), .FailValid(FailValid), .FirstFailIdx(FirstFailIdx),
    .Timeout(Timeout)
  );

  pipeline_selftest_ctrl #(.WDOG_MAX(16'd27)) dut_w (
    .Clk(Clk), .Rst(Rst), .FetchedPC(fpc), .dMemOut(dMemOut_w),
    .CkptIdx(CkptIdx_w), .CkptPC(CkptPC_w), .CkptExp(CkptExp_w),
    .PipeRst(PipeRst_w), .startPC(startPC_w), .Done(Done_w), .AllPassed(AllPassed_w),
    .PassCount(PassCount_w), .FailValid(FailValid_w), .FirstFailIdx(FirstFailIdx_w),
    .Timeout(Timeout_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; FetchedPC advances by 4 per cycle once the pipeline is out of reset.
  task automatic step();
    @(posedge Clk);
    #1;
    if (stuck)        fpc = 64'h20;
    else if (PipeRst) fpc = 64'h0;
    else              fpc = fpc + 64'd4;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_piperst"}, PipeRst, 1);
    check({tag, "_startpc"}, startPC, 64'h0);
    check({tag, "_idx"},     CkptIdx, 0);
    check({tag, "_pass"},    PassCount, 0);
    check({tag, "_done"},    Done, 0);
    check({tag, "_allp"},    AllPassed, 0);
    check({tag, "_failv"},   FailValid, 0);
    check({tag, "_ffidx"},   FirstFailIdx, 0);
    check({tag, "_tout"},    Timeout, 0);
    check({tag, "_w_done"},  Done_w, 0);
  endtask

  task automatic do_reset(input string tag);
    Rst = 1'b1;
    step();
    step();
    chk_reset(tag);
    Rst = 1'b0;
    repeat (4) step();
    step();
    check({tag, "_release"}, PipeRst, 0);
    cyc = 0;
  endtask

  initial begin
    // T1: reset values, then PipeRst held for exactly 5 edges
    #1;
    chk_reset("t1_async");
    repeat (5) step();
    chk_reset("t1_rst");
    Rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t1_hold", PipeRst, 1);
      check("t1_startpc", startPC, 64'h0);
    end
    step();
    check("t1_release", PipeRst, 0);
    cyc = 0;

    // T2: all checks pass; T6 runs alongside on dut_w
    run_to(26);
    check("t2_pre_pass", PassCount, 0);
    check("t6_pre_tout", Timeout_w, 0);
    check("t6_pre_done", Done_w, 0);
    run_to(27);
    check("t2_pass0", PassCount, 1);
    check("t2_idx1", CkptIdx, 1);
    check("t6_tout", Timeout_w, 1);
    check("t6_done", Done_w, 1);
    check("t6_pass", PassCount_w, 0);
    check("t6_allp", AllPassed_w, 0);
    check("t6_failv", FailValid_w, 0);
    run_to(68);
    check("t2_pre_done", Done, 0);
    check("t2_pre_pass1", PassCount, 1);
    run_to(69);
    check("t2_done", Done, 1);
    check("t2_pass", PassCount, 2);
    check("t2_allp", AllPassed, 1);
    check("t2_failv", FailValid, 0);
    check("t2_tout", Timeout, 0);
    check("t2_piperst", PipeRst, 0);
    run_to(75);
    check("t2_sticky", Done, 1);

    // T3: check 0 sees wrong data
    bad0 = 1'b1;
    do_reset("t3_rst");
    run_to(27);
    check("t3_failv0", FailValid, 1);
    check("t3_pass0", PassCount, 0);
    bad0 = 1'b0;
    run_to(69);
    check("t3_done", Done, 1);
    check("t3_pass", PassCount, 1);
    check("t3_failv", FailValid, 1);
    check("t3_ffidx", FirstFailIdx, 0);
    check("t3_allp", AllPassed, 0);

    // T5: async reset during the drain of check 1, then a clean rerun
    do_reset("t5_rst");
    run_to(66);
    check("t5_pre_pass", PassCount, 1);
    check("t5_pre_idx", CkptIdx, 1);
    #2 Rst = 1'b1;
    #1 chk_reset("t5_abort");
    step();
    step();
    Rst = 1'b0;
    repeat (4) step();
    step();
    check("t5_release", PipeRst, 0);
    cyc = 0;
    run_to(69);
    check("t5_done", Done, 1);
    check("t5_pass", PassCount, 2);
    check("t5_allp", AllPassed, 1);

    // T4: FetchedPC stuck below checkpoint 0
    stuck = 1'b1;
    do_reset("t4_rst");
    run_to(32766);
    check("t4_pre_tout", Timeout, 0);
    check("t4_pre_done", Done, 0);
    run_to(32767);
    check("t4_tout", Timeout, 1);
    check("t4_done", Done, 1);
    check("t4_allp", AllPassed, 0);
    check("t4_pass", PassCount, 0);
    check("t4_piperst", PipeRst, 0);
    run_to(32770);
    check("t4_sticky", Timeout, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
